// File: rtl/uart_response_arbiter_if.sv
// Byte-stream valid/ready handshake shared by the ASC, STL and UART TX ports of the arbiter.
interface uart_response_arbiter_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/uart_response_arbiter.sv
// Burst-holding round-robin arbiter merging ASC and STL response bytes onto one UART TX stream.
// Define RESP_TAG_EN to prefix every granted burst with a one-byte source tag.
module uart_response_arbiter #(
    parameter int unsigned IDLE_CLKS = 1000,
    parameter int unsigned MAX_BURST = 64,
    parameter logic [7:0]  ASC_TAG   = 8'h61,
    parameter logic [7:0]  STL_TAG   = 8'h73
) (
    input  logic                           clk,
    input  logic                           reset_n,
    uart_response_arbiter_if.slave         asc,
    uart_response_arbiter_if.slave         stl,
    uart_response_arbiter_if.master        tx,
    output logic [1:0]                     grant
);

    localparam int unsigned IDLE_W  = $clog2(IDLE_CLKS + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);
    localparam logic [IDLE_W-1:0]  IDLE_SAT  = IDLE_W'(IDLE_CLKS);
    localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT_ASC = 2'd1;
    localparam logic [1:0] GRANT_STL = 2'd2;
`ifdef RESP_TAG_EN
    localparam logic [1:0] TAG       = 2'd3;
`endif

    logic [1:0]         state_q, state_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               last_stl_q, last_stl_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic slot_free;
    logic asc_own, stl_own;
    logic own_valid, other_valid;
    logic burst_full, yield;
    logic asc_fire, stl_fire;
    logic start, start_stl;

`ifdef RESP_TAG_EN
    logic tag_stl_q, tag_stl_d;
    logic in_tag;
    logic tag_load;

    assign in_tag   = (state_q == TAG);
    assign tag_load = in_tag & slot_free;
`else
    logic [15:0] unused_tags;
    assign unused_tags = {ASC_TAG, STL_TAG};
`endif

    assign slot_free = !tx_valid_q | tx.ready;
    assign asc_own   = (state_q == GRANT_ASC);
    assign stl_own   = (state_q == GRANT_STL);

    assign own_valid   = asc_own ? asc.valid : stl.valid;
    assign other_valid = asc_own ? stl.valid : asc.valid;

    // At the cap the owner is held off for one cycle so the switch happens with no byte in flight.
    assign burst_full = (burst_cnt_q == BURST_CAP);
    assign yield      = burst_full & other_valid;

    assign asc.ready = asc_own & slot_free & !yield;
    assign stl.ready = stl_own & slot_free & !yield;

    assign asc_fire = asc.valid & asc.ready;
    assign stl_fire = stl.valid & stl.ready;

    assign tx.valid = tx_valid_q;
    assign tx.data  = tx_data_q;

`ifdef RESP_TAG_EN
    assign grant = {stl_own | (in_tag & tag_stl_q), asc_own | (in_tag & !tag_stl_q)};
`else
    assign grant = {stl_own, asc_own};
`endif

    // Output byte register.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (asc_fire) begin
            tx_valid_d = 1'b1;
            tx_data_d  = asc.data;
        end else if (stl_fire) begin
            tx_valid_d = 1'b1;
            tx_data_d  = stl.data;
`ifdef RESP_TAG_EN
        end else if (tag_load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = tag_stl_q ? STL_TAG : ASC_TAG;
`endif
        end else if (tx.ready) begin
            tx_valid_d = 1'b0;
        end
    end

    // Grant FSM and burst/idle counters.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        burst_cnt_d = burst_cnt_q;
        last_stl_d  = last_stl_q;
        start       = 1'b0;
        start_stl   = 1'b0;
`ifdef RESP_TAG_EN
        tag_stl_d   = tag_stl_q;
`endif

        case (state_q)
            IDLE: begin
                if (asc.valid | stl.valid) begin
                    start     = 1'b1;
                    start_stl = stl.valid & (!asc.valid | !last_stl_q);
                end
            end

            GRANT_ASC, GRANT_STL: begin
                if (asc_fire | stl_fire) begin
                    // A full counter is only reachable here when the other side is idle.
                    burst_cnt_d = burst_full ? BURST_W'(1) : burst_cnt_q + BURST_W'(1);
                    idle_cnt_d  = '0;
                end else if (yield) begin
                    start     = 1'b1;
                    start_stl = asc_own;
                end else begin
                    if (burst_full) begin
                        burst_cnt_d = '0;
                    end
                    if (!own_valid) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d     = IDLE;
                            idle_cnt_d  = '0;
                            burst_cnt_d = '0;
                        end else if (idle_cnt_q != IDLE_SAT) begin
                            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                        end
                    end
                end
            end

`ifdef RESP_TAG_EN
            TAG: begin
                if (slot_free) begin
                    state_d = tag_stl_q ? GRANT_STL : GRANT_ASC;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            idle_cnt_d  = '0;
            burst_cnt_d = '0;
            last_stl_d  = start_stl;
`ifdef RESP_TAG_EN
            state_d     = TAG;
            tag_stl_d   = start_stl;
`else
            state_d     = start_stl ? GRANT_STL : GRANT_ASC;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idle_cnt_q  <= '0;
            burst_cnt_q <= '0;
            last_stl_q  <= 1'b1;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            last_stl_q  <= last_stl_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

`ifdef RESP_TAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_stl_q <= 1'b0;
        end else begin
            tag_stl_q <= tag_stl_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_response_arbiter.sv
// Directed bench for uart_response_arbiter: queue-driven sources, a TX byte log, per-scenario tasks.
module tb_uart_response_arbiter;

    localparam int unsigned IDLE_CLKS = 16;
    localparam int unsigned MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant;

    uart_response_arbiter_if asc_if ();
    uart_response_arbiter_if stl_if ();
    uart_response_arbiter_if tx_if ();

    uart_response_arbiter #(
        .IDLE_CLKS (IDLE_CLKS),
        .MAX_BURST (MAX_BURST),
        .ASC_TAG   (8'h61),
        .STL_TAG   (8'h73)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .asc     (asc_if),
        .stl     (stl_if),
        .tx      (tx_if),
        .grant   (grant)
    );

    logic [7:0] asc_q[$];
    logic [7:0] stl_q[$];
    logic [7:0] out_q[$];
    int         out_cyc[$];
    int         asc_fire_cyc[$];
    int         stl_fire_cyc[$];
    int         cyc = 0;
    logic       tx_ready_cfg = 1'b1;
    int         checks = 0;
    int         passes = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Sources present the head of their queue; handshakes are logged just before each rising edge.
    initial begin
        asc_if.valid = 1'b0;
        asc_if.data  = 8'h00;
        stl_if.valid = 1'b0;
        stl_if.data  = 8'h00;
        tx_if.ready  = 1'b1;
        forever begin
            @(negedge clk);
            asc_if.valid = (asc_q.size() != 0);
            asc_if.data  = (asc_q.size() != 0) ? asc_q[0] : 8'h00;
            stl_if.valid = (stl_q.size() != 0);
            stl_if.data  = (stl_q.size() != 0) ? stl_q[0] : 8'h00;
            tx_if.ready  = tx_ready_cfg;
            #4;
            if (asc_if.valid && asc_if.ready) begin
                void'(asc_q.pop_front());
                asc_fire_cyc.push_back(cyc + 1);
            end
            if (stl_if.valid && stl_if.ready) begin
                void'(stl_q.pop_front());
                stl_fire_cyc.push_back(cyc + 1);
            end
            if (tx_if.valid && tx_if.ready) begin
                out_q.push_back(tx_if.data);
                out_cyc.push_back(cyc + 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic apply_reset();
        asc_q.delete();
        stl_q.delete();
        tx_ready_cfg = 1'b1;
        reset_n = 1'b0;
        tick(2);
        out_q.delete();
        out_cyc.delete();
        asc_fire_cyc.delete();
        stl_fire_cyc.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (tx_if.valid !== 1'b0 || tx_if.data !== 8'h00)
            $display("FAIL reset_tx: got valid=%b data=%h expected valid=0 data=00",
                     tx_if.valid, tx_if.data);
        else passes++;
        checks++;
        if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant);
        else passes++;
        checks++;
        if (asc_if.ready !== 1'b0 || stl_if.ready !== 1'b0)
            $display("FAIL reset_ready: got asc=%b stl=%b expected 0 0",
                     asc_if.ready, stl_if.ready);
        else passes++;

        // Park a byte in the output register, then reset asynchronously mid-cycle.
        tx_ready_cfg = 1'b0;
        asc_q = '{8'hC1, 8'hC2};
        tick(6);
        checks++;
        if (tx_if.valid !== 1'b1 || grant !== 2'b01)
            $display("FAIL reset_pre_busy: got valid=%b grant=%b expected 1 01",
                     tx_if.valid, grant);
        else passes++;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (tx_if.valid !== 1'b0) $display("FAIL async_reset_tx_valid: got %b expected 0",
                                           tx_if.valid);
        else passes++;
        checks++;
        if (grant !== 2'b00) $display("FAIL async_reset_grant: got %b expected 00", grant);
        else passes++;
        checks++;
        if (asc_if.ready !== 1'b0 || stl_if.ready !== 1'b0)
            $display("FAIL async_reset_ready: got asc=%b stl=%b expected 0 0",
                     asc_if.ready, stl_if.ready);
        else passes++;
        apply_reset();
    endtask

    task automatic test_asc_only();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         f;
        int         lat;
        apply_reset();
        exp_q = '{8'h11, 8'h22, 8'h33};
        asc_q = '{8'h11, 8'h22, 8'h33};
        wait_out(3, 60);
        checks++;
        if (out_q.size() != 3) $display("FAIL asc_only_count: got %0d expected 3", out_q.size());
        else passes++;
        for (int i = 0; i < 3; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL asc_only_data[%0d]: got %h expected %h",
                                           i, got, exp_q[i]);
            else passes++;
            lat = (i < out_cyc.size() && i < asc_fire_cyc.size()) ?
                  out_cyc[i] - asc_fire_cyc[i] : -1;
            checks++;
            if (lat != 1) $display("FAIL asc_only_latency[%0d]: got %0d expected 1", i, lat);
            else passes++;
        end
        checks++;
        if (grant !== 2'b01) $display("FAIL asc_only_grant: got %b expected 01", grant);
        else passes++;

        // Release happens on the IDLE_CLKS-th idle edge after the last accepted byte.
        f = (asc_fire_cyc.size() == 3) ? asc_fire_cyc[2] : cyc;
        while (cyc < f + int'(IDLE_CLKS) - 1) tick(1);
        checks++;
        if (grant !== 2'b01) $display("FAIL idle_hold_grant: got %b expected 01", grant);
        else passes++;
        tick(1);
        checks++;
        if (grant !== 2'b00) $display("FAIL idle_release_grant: got %b expected 00", grant);
        else passes++;
    endtask

    task automatic test_both_from_idle();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         gap;
        apply_reset();
        exp_q = '{8'h31, 8'h32, 8'h41, 8'h42};
        asc_q = '{8'h31, 8'h32};
        stl_q = '{8'h41, 8'h42};
        tick(2);
        checks++;
        if (grant !== 2'b01) $display("FAIL tie_first_grant: got %b expected 01", grant);
        else passes++;
        wait_out(4, 100);
        for (int i = 0; i < 4; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL tie_order[%0d]: got %h expected %h",
                                           i, got, exp_q[i]);
            else passes++;
        end
        // IDLE at F+16, GRANT_STL at F+17, first STL handshake at F+18.
        gap = (stl_fire_cyc.size() != 0 && asc_fire_cyc.size() == 2) ?
              stl_fire_cyc[0] - asc_fire_cyc[1] : -1;
        checks++;
        if (gap != int'(IDLE_CLKS) + 2)
            $display("FAIL tie_stl_after_timeout: got gap %0d expected %0d", gap, IDLE_CLKS + 2);
        else passes++;
    endtask

    task automatic test_burst_cap();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         gap;
        apply_reset();
        for (int i = 0; i < 10; i++) asc_q.push_back(8'hA0 + 8'(i));
        stl_q = '{8'hB0, 8'hB1, 8'hB2};
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2,
                  8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        wait_out(13, 200);
        tick(3);
        checks++;
        if (out_q.size() != 13) $display("FAIL burst_count: got %0d expected 13", out_q.size());
        else passes++;
        for (int i = 0; i < 13; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL burst_order[%0d]: got %h expected %h",
                                           i, got, exp_q[i]);
            else passes++;
        end
        // Direct switch: one dead cycle after the 4th ASC byte, then STL.
        gap = (stl_fire_cyc.size() != 0 && asc_fire_cyc.size() >= 4) ?
              stl_fire_cyc[0] - asc_fire_cyc[3] : -1;
        checks++;
        if (gap != 2) $display("FAIL burst_switch_gap: got %0d expected 2", gap);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        int         bad;
        apply_reset();
        tx_ready_cfg = 1'b0;
        exp_q = '{8'hC0, 8'hC1, 8'hC2};
        asc_q = '{8'hC0, 8'hC1, 8'hC2};
        tick(3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (tx_if.valid !== 1'b1 || tx_if.data !== 8'hC0 || asc_if.ready !== 1'b0) begin
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h asc_ready=%b expected 1 c0 0",
                         i, tx_if.valid, tx_if.data, asc_if.ready);
                bad++;
            end else passes++;
            tick(1);
        end
        tx_ready_cfg = 1'b1;
        wait_out(3, 50);
        tick(5);
        checks++;
        if (out_q.size() != 3) $display("FAIL stall_count: got %0d expected 3", out_q.size());
        else passes++;
        for (int i = 0; i < 3; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL stall_data[%0d]: got %h expected %h",
                                           i, got, exp_q[i]);
            else passes++;
        end
    endtask

`ifdef RESP_TAG_EN
    task automatic test_tag();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        apply_reset();
        exp_q = '{8'h73, 8'hA5, 8'h61, 8'h5A};
        stl_q = '{8'hA5};
        wait_out(2, 40);
        asc_q = '{8'h5A};
        wait_out(4, 100);
        tick(3);
        checks++;
        if (out_q.size() != 4) $display("FAIL tag_count: got %0d expected 4", out_q.size());
        else passes++;
        for (int i = 0; i < 4; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) $display("FAIL tag_stream[%0d]: got %h expected %h",
                                           i, got, exp_q[i]);
            else passes++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_asc_only();
        test_both_from_idle();
        test_burst_cap();
        test_backpressure();
`ifdef RESP_TAG_EN
        test_tag();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
